// File: rtl/desel_scan_ctrl.sv
// Scan controller for a 1-to-4 demux: latches a 4-bit word and presents it channel by channel.
// Build option DESEL_AUTO_RELOAD_EN: rescan the held word whenever DONE exits without a new load.
module desel_scan_ctrl #(
   parameter int unsigned DWELL = 4
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iLoad,
   input  logic [3:0] iData,
   output logic       oReady,
   output logic       oBusy,
   output logic       oC,
   output logic       oS1,
   output logic       oS0,
   output logic       oDone
);

   // A dwell of 0 behaves as a dwell of 1.
   localparam int unsigned DwellEff  = (DWELL == 0) ? 1 : DWELL;
   localparam logic [7:0]  DwellLast = 8'(DwellEff - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e     state_q;
   logic [3:0] word_q;
   logic [1:0] ch_q;
   logic [7:0] cnt_q;
   logic       ready_q;
   logic       busy_q;
   logic       c_q;
   logic [1:0] sel_q;
   logic       done_q;

   logic       start_scan;
   logic [3:0] start_word;
   logic [1:0] ch_next;
   logic       dwell_end;

   always_comb begin
      start_scan = 1'b0;
      start_word = word_q;
      ch_next    = ch_q + 2'd1;
      dwell_end  = (cnt_q == DwellLast);
      // ready_q is high exactly in IDLE and DONE, so it doubles as the load-accept window
      if (ready_q && iLoad) begin
         start_scan = 1'b1;
         start_word = iData;
      end
`ifdef DESEL_AUTO_RELOAD_EN
      else if (state_q == StDone) begin
         start_scan = 1'b1;
      end
`endif
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= StIdle;
         word_q  <= '0;
         ch_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         c_q     <= 1'b0;
         sel_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_scan) begin
            state_q <= StScan;
            word_q  <= start_word;
            ch_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            c_q     <= start_word[0];
            sel_q   <= 2'd0;
         end else begin
            unique case (state_q)
               StIdle: ;
               StScan: begin
                  if (!dwell_end) begin
                     cnt_q <= cnt_q + 8'd1;
                  end else if (ch_q != 2'd3) begin
                     // data and select move together so the demux never sees a mismatch
                     cnt_q <= '0;
                     ch_q  <= ch_next;
                     c_q   <= word_q[ch_next];
                     sel_q <= ch_next;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     c_q     <= 1'b0;
                     sel_q   <= '0;
                     done_q  <= 1'b1;
                  end
               end
               StDone: state_q <= StIdle;
               default: begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  c_q     <= 1'b0;
                  sel_q   <= '0;
               end
            endcase
         end
      end
   end

   assign oReady = ready_q;
   assign oBusy  = busy_q;
   assign oC     = c_q;
   assign oS1    = sel_q[1];
   assign oS0    = sel_q[0];
   assign oDone  = done_q;

endmodule

// File: tb/tb_desel_scan_ctrl.sv
// Bench for desel_scan_ctrl: DWELL=4 and DWELL=1 instances, per-cycle expectations via scoreboard.
module tb_desel_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load4, load1;
   logic [3:0] data4, data1;
   logic       rdy4, bsy4, c4, s14, s04, dn4;
   logic       rdy1, bsy1, c1, s11, s01, dn1;
   logic [5:0] o4, o1;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   desel_scan_ctrl #(.DWELL(4)) u_dut4 (
      .iClk(clk), .iRst_n(rst_n), .iLoad(load4), .iData(data4),
      .oReady(rdy4), .oBusy(bsy4), .oC(c4), .oS1(s14), .oS0(s04), .oDone(dn4)
   );

   desel_scan_ctrl #(.DWELL(1)) u_dut1 (
      .iClk(clk), .iRst_n(rst_n), .iLoad(load1), .iData(data1),
      .oReady(rdy1), .oBusy(bsy1), .oC(c1), .oS1(s11), .oS0(s01), .oDone(dn1)
   );

   // Output word layout: {ready, busy, c, s1, s0, done}
   assign o4 = {rdy4, bsy4, c4, s14, s04, dn4};
   assign o1 = {rdy1, bsy1, c1, s11, s01, dn1};

   typedef struct {
      int         cyc;
      logic [5:0] exp;
      string      name;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   exp_t x4, x1;

   typedef struct {
      string      name;
      logic [3:0] data;
      int         ign_at;
      logic [3:0] ign_data;
      logic [3:0] exp_c;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b {rdy,busy,c,s1,s0,done} cycle %0d", nm, act, exp,
                  cyc);
      end
   endtask

   task automatic push(input int inst, input int c, input logic [5:0] e, input string nm);
      exp_t x;
      x.cyc  = c;
      x.exp  = e;
      x.name = nm;
      if (inst == 4) q4.push_back(x);
      else q1.push_back(x);
   endtask

   // Channel k occupies cycles tl+1+k*d .. tl+(k+1)*d; DONE follows at tl+1+4*d.
   task automatic push_scan(input int inst, input int tl, input logic [3:0] w, input int d,
                            input string nm);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < d; j++) begin
            push(inst, tl + 1 + k * d + j, {1'b0, 1'b1, w[k], 2'(k), 1'b0}, nm);
         end
      end
      push(inst, tl + 1 + 4 * d, 6'b100001, {nm, "_done"});
   endtask

   task automatic push_tail(input int inst, input int tdone, input logic [3:0] w, input int d,
                            input string nm);
`ifdef DESEL_AUTO_RELOAD_EN
      push_scan(inst, tdone, w, d, {nm, "_reload"});
`else
      for (int c = tdone + 1; c <= tdone + 1 + 4 * d; c++) push(inst, c, 6'b100000, {nm, "_idle"});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      while (q4.size() > 0 && q4[0].cyc <= cyc) begin
         x4 = q4.pop_front();
         if (x4.cyc < cyc) check({x4.name, "_missed"}, 6'bxxxxxx, x4.exp);
         else check(x4.name, o4, x4.exp);
      end
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
         x1 = q1.pop_front();
         if (x1.cyc < cyc) check({x1.name, "_missed"}, 6'bxxxxxx, x1.exp);
         else check(x1.name, o1, x1.exp);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required finish before 100000ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vecs[0] = '{"scan_1010", 4'b1010, 0,  4'h0, 4'b1010};
      vecs[1] = '{"scan_0101", 4'b0101, 0,  4'h0, 4'b0101};
      vecs[2] = '{"ign_in_F",  4'hF,    6,  4'h0, 4'hF};
      vecs[3] = '{"ign_in_0",  4'h0,    10, 4'hF, 4'h0};
      vecs[4] = '{"scan_0001", 4'b0001, 0,  4'h0, 4'b0001};
      vecs[5] = '{"scan_1000", 4'b1000, 3,  4'h7, 4'b1000};

      // Reset held with a load request present
      rst_n = 1'b0;
      load4 = 1'b1;
      load1 = 1'b1;
      data4 = 4'hF;
      data1 = 4'hF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_out_d4", o4, 6'b100000);
      check("reset_out_d1", o1, 6'b100000);
      step();
      rst_n = 1'b1;
      load4 = 1'b0;
      load1 = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         step();
         t = cyc;
         push(4, t, 6'b100000, {vecs[i].name, "_ready"});
         load4 = 1'b1;
         data4 = vecs[i].data;
         push_scan(4, t, vecs[i].exp_c, 4, vecs[i].name);
         push_tail(4, t + 17, vecs[i].exp_c, 4, vecs[i].name);
         step();
         while (cyc <= t + 34) begin
            if (vecs[i].ign_at != 0 && cyc == t + vecs[i].ign_at) begin
               load4 = 1'b1;
               data4 = vecs[i].ign_data;
            end else begin
               load4 = 1'b0;
               data4 = ~vecs[i].data;
            end
            step();
         end
         load4 = 1'b0;
         do_reset();
      end

      // Back-to-back loads on the DWELL=1 instance, load held high throughout
      step();
      t = cyc;
      push(1, t, 6'b100000, "b2b_ready");
      load1 = 1'b1;
      data1 = 4'h5;
      push_scan(1, t, 4'h5, 1, "b2b_a");
      push_scan(1, t + 5, 4'hA, 1, "b2b_b");
      push_tail(1, t + 10, 4'hA, 1, "b2b");
      while (cyc < t + 5) step();
      data1 = 4'hA;
      step();
      load1 = 1'b0;
      data1 = 4'h0;
      while (cyc <= t + 15) step();
      do_reset();

      // Reset asserted during channel 2 aborts the scan with no done pulse
      step();
      t = cyc;
      push(4, t, 6'b100000, "mid_ready");
      load4 = 1'b1;
      data4 = 4'b0110;
      push_scan(4, t, 4'b0110, 4, "mid");
      step();
      load4 = 1'b0;
      while (cyc < t + 10) step();
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_async", o4, 6'b100000);
      q4.delete();
      for (int c = t + 10; c <= t + 24; c++) push(4, c, 6'b100000, "mid_after_rst");
      step();
      step();
      rst_n = 1'b1;
      while (cyc <= t + 25) step();

      step();
      n_chk++;
      if (q4.size() + q1.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, required 0", q4.size() + q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
